br_counter_decr: RTL and testbench

- Decrementing counter; the counterpart of the incrementing counter. It pairs with it for credit return, occupancy tracking and countdown timers.
- Each cycle it subtracts a variable amount, from 0 up to MaxDecrement inclusive.
- On underflow past 0 it either wraps modulo MaxValue+1 or saturates at 0.
- Exposes the registered `value`, the combinational `value_next` for single-cycle chaining, and an `underflow` indication.

---
 rtl/br_counter_decr.sv | 128 ++++++++++++
 tb/tb_br_counter_decr.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_counter_decr.sv
// br_counter_decr: down-counter with a variable per-cycle decrement.
// When the decrement goes below 0 the counter either wraps modulo MaxValue+1 or saturates at 0.
// It exposes the registered value, the combinational value_next and an underflow flag.
// Optional feature: define BR_COUNTER_DECR_UNDERFLOW_STICKY_EN to add the underflow_sticky output.
module br_counter_decr #(
    parameter int unsigned                  MaxValueWidth             = 32,
    parameter int unsigned                  MaxDecrementWidth         = 32,
    parameter logic [MaxValueWidth-1:0]     MaxValue                  = 1,
    parameter logic [MaxDecrementWidth-1:0] MaxDecrement              = 1,
    parameter logic [MaxValueWidth-1:0]     ResetValue                = 0,
    parameter bit                           EnableReinitAndDecr       = 1'b1,
    parameter bit                           EnableSaturate            = 1'b0,
    parameter bit                           EnableAssertFinalNotValid = 1'b1,
    localparam int unsigned ValueWidth     = $clog2(64'(MaxValue) + 64'd1),
    localparam int unsigned DecrementWidth = $clog2(64'(MaxDecrement) + 64'd1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reinit,
    input  logic [ValueWidth-1:0]     initial_value,
    input  logic                      decr_valid,
    input  logic [DecrementWidth-1:0] decr,
    output logic [ValueWidth-1:0]     value,
    output logic [ValueWidth-1:0]     value_next,
`ifdef BR_COUNTER_DECR_UNDERFLOW_STICKY_EN
    output logic                      underflow,
    output logic                      underflow_sticky
`else
    output logic                      underflow
`endif
);

    // One guard bit above the wider operand makes the difference's MSB a borrow flag.
    localparam int unsigned WideWidth =
        ((ValueWidth > DecrementWidth) ? ValueWidth : DecrementWidth) + 1;
    localparam bit ModulusIsPow2 =
        ((64'(MaxValue) + 64'd1) & 64'(MaxValue)) == 64'd0;
    localparam logic [ValueWidth-1:0] ModulusLow = ValueWidth'(64'(MaxValue) + 64'd1);

    logic                  decr_applied;
    logic [WideWidth-1:0]  base_w;
    logic [WideWidth-1:0]  decr_w;
    logic [WideWidth-1:0]  diff_w;
    logic [ValueWidth-1:0] wrapped;

    // Next-value datapath: select base, subtract, then wrap or saturate on underflow.
    always_comb begin
        decr_applied = decr_valid && (EnableReinitAndDecr || !reinit);
        base_w       = WideWidth'(reinit ? initial_value : value);
        decr_w       = decr_applied ? WideWidth'(decr) : '0;
        diff_w       = base_w - decr_w;
        // Both operands sit below the guard bit, so a set MSB means decr_w > base_w.
        underflow    = diff_w[WideWidth-1];
        // A power-of-2 modulus is plain truncation; otherwise add MaxValue+1 back in.
        wrapped      = ModulusIsPow2 ? diff_w[ValueWidth-1:0]
                                     : diff_w[ValueWidth-1:0] + ModulusLow;
        if (!underflow) begin
            value_next = diff_w[ValueWidth-1:0];
        end else if (EnableSaturate) begin
            value_next = '0;
        end else begin
            value_next = wrapped;
        end
    end

    // Counter state: load on reinit or decrement, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= ResetValue[ValueWidth-1:0];
        end else if (decr_valid || reinit) begin
            value <= value_next;
        end
    end

`ifdef BR_COUNTER_DECR_UNDERFLOW_STICKY_EN
    // Sticky underflow: set wins over a clearing reinit in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_sticky <= 1'b0;
        end else if (underflow) begin
            underflow_sticky <= 1'b1;
        end else if (reinit) begin
            underflow_sticky <= 1'b0;
        end
    end
`endif

`ifndef SYNTHESIS
    if (64'(MaxValue) < 64'd1) begin : gen_bad_max_value
        $error("MaxValue must be >= 1");
    end
    if (64'(MaxDecrement) < 64'd1 || 64'(MaxDecrement) > 64'(MaxValue)) begin : gen_bad_max_decr
        $error("MaxDecrement must be in [1, MaxValue]");
    end
    if (64'(ResetValue) > 64'(MaxValue)) begin : gen_bad_reset_value
        $error("ResetValue must be <= MaxValue");
    end

    a_decr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        decr_valid |-> (MaxDecrementWidth'(decr) <= MaxDecrement));
    a_init_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        MaxValueWidth'(initial_value) <= MaxValue);
    a_value_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        MaxValueWidth'(value) <= MaxValue);
    a_value_next_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        MaxValueWidth'(value_next) <= MaxValue);
    a_value_follows_next: assert property (@(posedge clk) disable iff (!rst_n)
        $past(rst_n) |-> (value == $past(value_next)));
`ifdef BR_COUNTER_DECR_UNDERFLOW_STICKY_EN
    a_sticky_set: assert property (@(posedge clk) disable iff (!rst_n)
        underflow |=> underflow_sticky);
`endif

    c_max_decr: cover property (@(posedge clk) disable iff (!rst_n)
        decr_valid && (MaxDecrementWidth'(decr) == MaxDecrement));
    c_underflow: cover property (@(posedge clk) disable iff (!rst_n) underflow);
    c_reinit_and_decr: cover property (@(posedge clk) disable iff (!rst_n)
        reinit && decr_valid && (decr != '0));

    // Callers must leave decr_valid low when the run ends.
    final begin
        if (EnableAssertFinalNotValid) begin
            a_final_not_valid: assert (!decr_valid);
        end
    end
`endif

endmodule

// File: tb/tb_br_counter_decr.sv
// Bench for br_counter_decr: three instances (wrap/9, saturate/9 no reinit-decr, wrap/7)
// share control inputs and are checked against an arithmetic reference model.
// Define BR_COUNTER_DECR_UNDERFLOW_STICKY_EN to also check underflow_sticky.
module tb_br_counter_decr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       reinit = 1'b0;
    logic       decr_valid = 1'b0;
    logic [1:0] decr = '0;
    logic [3:0] iv9 = '0;
    logic [2:0] iv7 = '0;

    logic [3:0] val_a, nxt_a, val_b, nxt_b;
    logic [2:0] val_c, nxt_c;
    logic       unf_a, unf_b, unf_c;
`ifdef BR_COUNTER_DECR_UNDERFLOW_STICKY_EN
    logic       stk_a, stk_b, stk_c;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int m_val[3];
    int m_stk[3];

    always #5 clk = ~clk;

    br_counter_decr #(.MaxValue(9), .MaxDecrement(3), .ResetValue(5),
                      .EnableReinitAndDecr(1'b1), .EnableSaturate(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .reinit(reinit), .initial_value(iv9),
        .decr_valid(decr_valid), .decr(decr), .value(val_a), .value_next(nxt_a),
`ifdef BR_COUNTER_DECR_UNDERFLOW_STICKY_EN
        .underflow(unf_a), .underflow_sticky(stk_a)
`else
        .underflow(unf_a)
`endif
    );

    br_counter_decr #(.MaxValue(9), .MaxDecrement(3), .ResetValue(5),
                      .EnableReinitAndDecr(1'b0), .EnableSaturate(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .reinit(reinit), .initial_value(iv9),
        .decr_valid(decr_valid), .decr(decr), .value(val_b), .value_next(nxt_b),
`ifdef BR_COUNTER_DECR_UNDERFLOW_STICKY_EN
        .underflow(unf_b), .underflow_sticky(stk_b)
`else
        .underflow(unf_b)
`endif
    );

    br_counter_decr #(.MaxValue(7), .MaxDecrement(3), .ResetValue(3),
                      .EnableReinitAndDecr(1'b1), .EnableSaturate(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .reinit(reinit), .initial_value(iv7),
        .decr_valid(decr_valid), .decr(decr), .value(val_c), .value_next(nxt_c),
`ifdef BR_COUNTER_DECR_UNDERFLOW_STICKY_EN
        .underflow(unf_c), .underflow_sticky(stk_c)
`else
        .underflow(unf_c)
`endif
    );

    function automatic int max_v(input int i);
        return (i == 2) ? 7 : 9;
    endfunction

    function automatic int rst_v(input int i);
        return (i == 2) ? 3 : 5;
    endfunction

    task automatic check_eq(input string tag, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: base, amount, then wrap (add modulus) or clamp, straight from the rules.
    function automatic void model_next(input int i, output int nxt, output bit unf);
        int  base;
        int  d;
        bit  sat;
        bit  reinit_decr;
        sat         = (i == 1);
        reinit_decr = (i != 1);
        base = reinit ? ((i == 2) ? int'(iv7) : int'(iv9)) : m_val[i];
        d    = (decr_valid && (reinit_decr || !reinit)) ? int'(decr) : 0;
        unf  = d > base;
        if (!unf)     nxt = base - d;
        else if (sat) nxt = 0;
        else          nxt = base - d + max_v(i) + 1;
    endfunction

    function automatic int obs_val(input int i);
        case (i)
            0:       return int'(val_a);
            1:       return int'(val_b);
            default: return int'(val_c);
        endcase
    endfunction

    function automatic int obs_nxt(input int i);
        case (i)
            0:       return int'(nxt_a);
            1:       return int'(nxt_b);
            default: return int'(nxt_c);
        endcase
    endfunction

    function automatic int obs_unf(input int i);
        case (i)
            0:       return int'(unf_a);
            1:       return int'(unf_b);
            default: return int'(unf_c);
        endcase
    endfunction

`ifdef BR_COUNTER_DECR_UNDERFLOW_STICKY_EN
    function automatic int obs_stk(input int i);
        case (i)
            0:       return int'(stk_a);
            1:       return int'(stk_b);
            default: return int'(stk_c);
        endcase
    endfunction
`endif

    task automatic reset_model();
        for (int i = 0; i < 3; i++) begin
            m_val[i] = rst_v(i);
            m_stk[i] = 0;
        end
    endtask

    // Called just after a negedge: apply inputs, then compare all instances to the model.
    task automatic drive(input bit r, input int i9, input int i7, input bit dv, input int d);
        int nxt;
        bit unf;
        reinit     = r;
        iv9        = 4'(i9);
        iv7        = 3'(i7);
        decr_valid = dv;
        decr       = 2'(d);
        #1;
        for (int i = 0; i < 3; i++) begin
            model_next(i, nxt, unf);
            check_eq($sformatf("value[%0d]", i), obs_val(i), m_val[i]);
            check_eq($sformatf("value_next[%0d]", i), obs_nxt(i), nxt);
            check_eq($sformatf("underflow[%0d]", i), obs_unf(i), int'(unf));
`ifdef BR_COUNTER_DECR_UNDERFLOW_STICKY_EN
            check_eq($sformatf("sticky[%0d]", i), obs_stk(i), m_stk[i]);
`endif
        end
    endtask

    // Step the model across one posedge and return at the following negedge.
    task automatic advance();
        int nxt[3];
        bit unf[3];
        for (int i = 0; i < 3; i++) model_next(i, nxt[i], unf[i]);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (decr_valid || reinit) m_val[i] = nxt[i];
            if (unf[i])      m_stk[i] = 1;
            else if (reinit) m_stk[i] = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle_step();
        drive(1'b0, 0, 0, 1'b0, 0);
        advance();
    endtask

    initial begin
        reset_model();
        #12;
        check_eq("reset_a", int'(val_a), 5);
        check_eq("reset_c", int'(val_c), 3);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after release: value holds ResetValue and value_next mirrors it.
        drive(1'b0, 0, 0, 1'b0, 0);
        check_eq("post_rst_val", int'(val_a), 5);
        check_eq("post_rst_next", int'(nxt_a), 5);
        advance();

        // Asynchronous reset mid-cycle takes effect without a clock edge.
        drive(1'b1, 2, 2, 1'b0, 0);
        advance();
        drive(1'b0, 0, 0, 1'b0, 0);
        check_eq("pre_async_val", int'(val_a), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_a", int'(val_a), 5);
        check_eq("async_rst_c", int'(val_c), 3);
        reset_model();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_step();

        // Underflow from 1 by 3: wrap gives 8, saturate gives 0.
        drive(1'b1, 1, 1, 1'b0, 0);
        advance();
        drive(1'b0, 0, 0, 1'b1, 3);
        check_eq("wrap_unf", int'(unf_a), 1);
        check_eq("wrap_next", int'(nxt_a), 8);
        check_eq("sat_unf", int'(unf_b), 1);
        check_eq("sat_next", int'(nxt_b), 0);
        advance();
        drive(1'b0, 0, 0, 1'b1, 2);
        check_eq("wrap_val", int'(val_a), 8);
        check_eq("sat_hold_next", int'(nxt_b), 0);
        advance();
        drive(1'b0, 0, 0, 1'b0, 0);
        check_eq("sat_hold_val", int'(val_b), 0);
        advance();

        // Reinit with a decrement: applied on u_a, ignored on u_b.
        drive(1'b1, 2, 2, 1'b0, 0);
        advance();
        drive(1'b1, 7, 7, 1'b1, 2);
        check_eq("reinit_nodecr_unf", int'(unf_b), 0);
        check_eq("reinit_nodecr_next", int'(nxt_b), 7);
        advance();
        drive(1'b0, 0, 0, 1'b0, 0);
        check_eq("reinit_decr_val", int'(val_a), 5);
        check_eq("reinit_nodecr_val", int'(val_b), 7);
        check_eq("reinit_decr_c", int'(val_c), 5);
        advance();

        // Power-of-2 wrap on u_c, then a zero decrement holds the value.
        drive(1'b1, 0, 0, 1'b0, 0);
        advance();
        drive(1'b0, 0, 0, 1'b1, 1);
        check_eq("pow2_next", int'(nxt_c), 7);
        check_eq("pow2_unf", int'(unf_c), 1);
        advance();
        drive(1'b1, 4, 4, 1'b0, 0);
        advance();
        drive(1'b0, 0, 0, 1'b1, 0);
        check_eq("zero_decr_unf", int'(unf_c), 0);
        check_eq("zero_decr_next", int'(nxt_c), 4);
        advance();
        drive(1'b0, 0, 0, 1'b0, 0);
        check_eq("zero_decr_val", int'(val_c), 4);
        advance();

`ifdef BR_COUNTER_DECR_UNDERFLOW_STICKY_EN
        // Sticky: set after underflow, survives plain decrements, cleared by clean reinit.
        drive(1'b1, 0, 0, 1'b0, 0);
        advance();
        drive(1'b0, 0, 0, 1'b1, 1);
        advance();
        drive(1'b0, 0, 0, 1'b1, 1);
        check_eq("sticky_set", int'(stk_a), 1);
        advance();
        drive(1'b0, 0, 0, 1'b0, 0);
        check_eq("sticky_held", int'(stk_a), 1);
        advance();
        drive(1'b1, 5, 5, 1'b0, 0);
        advance();
        drive(1'b0, 0, 0, 1'b0, 0);
        check_eq("sticky_cleared", int'(stk_a), 0);
        advance();
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 7) == 0, int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 3)));
            advance();
        end

        idle_step();
        decr_valid = 1'b0;
        reinit     = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
